// File: rtl/md6_pkg.sv
// Shared definitions for the Mega Drive 6-button pad reader: scan states,
// vj bit positions and pad pin positions for each select level.
package md6_pkg;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_P6,
    ST_P7
  } state_e;

  // Bit positions inside the vj output word
  localparam int VJ_R     = 0;
  localparam int VJ_L     = 1;
  localparam int VJ_D     = 2;
  localparam int VJ_U     = 3;
  localparam int VJ_B     = 4;
  localparam int VJ_C     = 5;
  localparam int VJ_A     = 6;
  localparam int VJ_START = 7;
  localparam int VJ_Y     = 8;
  localparam int VJ_Z     = 9;
  localparam int VJ_X     = 10;

  // Pad pins while select is high (normal read)
  localparam int HI_U = 0;
  localparam int HI_D = 1;
  localparam int HI_L = 2;
  localparam int HI_R = 3;
  localparam int HI_B = 4;
  localparam int HI_C = 5;

  // Pad pins while select is low; ID pins read 00 when a pad is attached
  localparam int LO_ID0   = 2;
  localparam int LO_ID1   = 3;
  localparam int LO_A     = 4;
  localparam int LO_START = 5;

  // Pad pins on the fourth high select of a 6-button pad
  localparam int X6_Z = 0;
  localparam int X6_Y = 1;
  localparam int X6_X = 2;

  // Select level driven to the pad in a given state
  function automatic logic pin_level(state_e s);
    return (s == ST_WAIT) || (s == ST_P0) || (s == ST_P2) ||
           (s == ST_P4) || (s == ST_P6);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so
// active-low pad pins read as released while the reader is held in reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the raw input through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/md6_joystick_reader.sv
// Mega Drive 3/6-button pad reader: idles with select high long enough for
// the pad's counter to time out, then toggles select through eight phases,
// sampling at the end of each phase and committing one result per scan.
module md6_joystick_reader
  import md6_pkg::*;
#(
  parameter int PHASE_CYCLES = 280,
  parameter int IDLE_CYCLES  = 56000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [5:0]  data_bits,
  output logic        pin_7,
  output logic [10:0] vj,
  output logic        present,
  output logic        six_button,
  output logic        valid
);

  localparam int MAX_CYCLES = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);

  logic [5:0] pad_sync;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pin_7_q, pin_7_d;
  logic [5:0]    hi_btn_q, hi_btn_d;
  logic [1:0]    lo_btn_q, lo_btn_d;
  logic          present_stg_q, present_stg_d;
  logic          six_stg_q, six_stg_d;
  logic [2:0]    xyz_q, xyz_d;
  logic [10:0]   vj_q, vj_d;
  logic          present_q, present_d;
  logic          six_q, six_d;
  logic          valid_q, valid_d;
  logic          phase_end;

  sync_2ff #(.WIDTH(6)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_bits),
    .q     (pad_sync)
  );

  // Next-state, phase timing, end-of-phase sampling and atomic commit
  always_comb begin
    phase_end     = (cnt_q == PHASE_LAST);
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_btn_d      = hi_btn_q;
    lo_btn_d      = lo_btn_q;
    present_stg_d = present_stg_q;
    six_stg_d     = six_stg_q;
    xyz_d         = xyz_q;
    vj_d          = vj_q;
    present_d     = present_q;
    six_d         = six_q;
    valid_d       = 1'b0;

    if (state_q == ST_WAIT) begin
      if (cnt_q == IDLE_LAST) begin
        if (scan_en) begin
          state_d = ST_P0;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (phase_end) begin
      cnt_d   = '0;
      state_d = (state_q == ST_P7) ? ST_WAIT : state_e'(state_q + 4'd1);
      case (state_q)
        ST_P0: hi_btn_d = ~pad_sync;
        ST_P1: begin
          lo_btn_d      = {~pad_sync[LO_START], ~pad_sync[LO_A]};
          present_stg_d = ~pad_sync[LO_ID1] & ~pad_sync[LO_ID0];
        end
        ST_P5: six_stg_d = present_stg_q & (pad_sync[3:0] == 4'b0000);
        ST_P6: xyz_d = ~pad_sync[2:0];
        ST_P7: begin
          valid_d   = 1'b1;
          present_d = present_stg_q;
          six_d     = present_stg_q & six_stg_q;
          vj_d      = '0;
          if (present_stg_q) begin
            vj_d[VJ_R]     = hi_btn_q[HI_R];
            vj_d[VJ_L]     = hi_btn_q[HI_L];
            vj_d[VJ_D]     = hi_btn_q[HI_D];
            vj_d[VJ_U]     = hi_btn_q[HI_U];
            vj_d[VJ_B]     = hi_btn_q[HI_B];
            vj_d[VJ_C]     = hi_btn_q[HI_C];
            vj_d[VJ_A]     = lo_btn_q[0];
            vj_d[VJ_START] = lo_btn_q[1];
            if (six_stg_q) begin
              vj_d[VJ_X] = xyz_q[X6_X];
              vj_d[VJ_Y] = xyz_q[X6_Y];
              vj_d[VJ_Z] = xyz_q[X6_Z];
            end
          end
        end
        default: ;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pin_7_d = pin_level(state_d);
  end

  // State, staging and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      pin_7_q       <= 1'b1;
      hi_btn_q      <= '0;
      lo_btn_q      <= '0;
      present_stg_q <= 1'b0;
      six_stg_q     <= 1'b0;
      xyz_q         <= '0;
      vj_q          <= '0;
      present_q     <= 1'b0;
      six_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pin_7_q       <= pin_7_d;
      hi_btn_q      <= hi_btn_d;
      lo_btn_q      <= lo_btn_d;
      present_stg_q <= present_stg_d;
      six_stg_q     <= six_stg_d;
      xyz_q         <= xyz_d;
      vj_q          <= vj_d;
      present_q     <= present_d;
      six_q         <= six_d;
      valid_q       <= valid_d;
    end
  end

  assign pin_7      = pin_7_q;
  assign vj         = vj_q;
  assign present    = present_q;
  assign six_button = six_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_md6_joystick_reader.sv
// Bench for md6_joystick_reader: a behavioural pad drives data_bits from the
// select line, and a timeline model predicts pin_7 and every committed result.
module tb_md6_joystick_reader;

  localparam int PHASE       = 4;
  localparam int IDLE        = 64;
  localparam int SCAN        = 8 * PHASE;
  localparam int PERIOD      = IDLE + SCAN;
  localparam int PAD_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_en = 1'b1;
  logic [5:0]  data_bits;
  logic        pin_7;
  logic [10:0] vj;
  logic        present;
  logic        six_button;
  logic        valid;

  int errors = 0;
  int checks = 0;

  // Pad configuration: mode 0 = unplugged, 1 = 3-button, 2 = 6-button;
  // buttons held in vj bit order, active-high
  int          pad_mode = 2;
  logic [10:0] pad_btn  = 11'h041;
  int          fall_cnt = 0;
  int          high_cnt = 0;
  logic        prev_sel = 1'b1;

  md6_joystick_reader #(
    .PHASE_CYCLES (PHASE),
    .IDLE_CYCLES  (IDLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .data_bits  (data_bits),
    .pin_7      (pin_7),
    .vj         (vj),
    .present    (present),
    .six_button (six_button),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // What the pad puts on its pins for a given select level and count of
  // select falls since its counter last timed out
  function automatic logic [5:0] pad_pins(int mode, logic [10:0] b, logic sel, int falls);
    logic [5:0] p;
    if (mode == 0) return 6'h3F;
    if (sel === 1'b1) begin
      if (mode == 2 && falls == 3) p = {b[5], b[4], 1'b0, b[10], b[8], b[9]};
      else                         p = {b[5], b[4], b[0], b[1], b[2], b[3]};
      return ~p;
    end
    if (mode == 2 && falls == 3) return {~b[7], ~b[6], 4'b0000};
    if (mode == 2 && falls == 4) return {~b[7], ~b[6], 4'b1111};
    return {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
  endfunction

  assign data_bits = pad_pins(pad_mode, pad_btn, pin_7, fall_cnt);

  // Pad's internal counter: counts select falls, clears after a long high
  always @(posedge clk) begin
    #2;
    if (prev_sel === 1'b1 && pin_7 === 1'b0) fall_cnt = fall_cnt + 1;
    if (pin_7 === 1'b1) begin
      high_cnt = high_cnt + 1;
      if (high_cnt > PAD_TIMEOUT) fall_cnt = 0;
    end else begin
      high_cnt = 0;
    end
    prev_sel = pin_7;
  end

  // Reference timeline: wait position m_w, scan position m_s (both 1-based
  // cycle numbers of the current cycle) and the expected outputs
  logic        m_armed = 1'b0;
  logic        m_in_scan = 1'b0;
  int          m_w = 1;
  int          m_s = 1;
  logic        m_pin = 1'b1;
  logic        m_valid = 1'b0;
  logic [10:0] m_vj = '0;
  logic        m_present = 1'b0;
  logic        m_six = 1'b0;
  logic [10:0] m_snap_vj = '0;
  logic        m_snap_present = 1'b0;
  logic        m_snap_six = 1'b0;

  // Advance the model on each clock edge using the inputs the DUT sees
  always @(posedge clk) begin
    m_valid = 1'b0;
    if (!reset) begin
      m_armed   = 1'b1;
      m_in_scan = 1'b0;
      m_w       = 1;
      m_vj      = '0;
      m_present = 1'b0;
      m_six     = 1'b0;
    end else if (m_armed) begin
      if (!m_in_scan) begin
        if (m_w >= IDLE && scan_en) begin
          m_in_scan      = 1'b1;
          m_s            = 1;
          m_snap_present = (pad_mode != 0);
          m_snap_six     = (pad_mode == 2);
          m_snap_vj      = (pad_mode == 0) ? 11'h000 :
                           (pad_mode == 2) ? pad_btn : (pad_btn & 11'h0FF);
        end else begin
          m_w = m_w + 1;
        end
      end else if (m_s == SCAN) begin
        m_in_scan = 1'b0;
        m_w       = 1;
        m_vj      = m_snap_vj;
        m_present = m_snap_present;
        m_six     = m_snap_six;
        m_valid   = 1'b1;
      end else begin
        m_s = m_s + 1;
      end
    end
    m_pin = m_in_scan ? ((((m_s - 1) / PHASE) % 2) == 0) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(posedge clk) begin
    #1;
    if (m_armed) begin
      checkOutput("pin_7", 11'(pin_7), 11'(m_pin));
      checkOutput("valid", 11'(valid), 11'(m_valid));
      checkOutput("vj", vj, m_vj);
      checkOutput("present", 11'(present), 11'(m_present));
      checkOutput("six_button", 11'(six_button), 11'(m_six));
    end
  end

  task automatic applyStimulus(input int mode, input logic [10:0] btn);
    @(negedge clk);
    pad_mode = mode;
    pad_btn  = btn;
  endtask

  task automatic waitValid(input int max_cycles, input string name, output int waited);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited = waited + 1;
    end while (valid !== 1'b1 && waited < max_cycles);
    checks = checks + 1;
    if (valid !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: valid got 0 expected 1 within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic waitScanPos(input int pos, input int max_cycles, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!(m_in_scan && m_s == pos) && n < max_cycles);
    checks = checks + 1;
    if (!(m_in_scan && m_s == pos)) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: scan position %0d not reached within %0d cycles", name, pos, max_cycles);
    end
  endtask

  task automatic holdQuiet(input int n, input string name);
    int lows = 0;
    int vals = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pin_7 !== 1'b1) lows = lows + 1;
      if (valid !== 1'b0) vals = vals + 1;
    end
    checkOutput({name, "_pin7_low_cycles"}, 11'(lows), 11'd0);
    checkOutput({name, "_valids"}, 11'(vals), 11'd0);
  endtask

  // Directed tests followed by randomized scans
  initial begin
    int          waited;
    int          wave_bad;
    int          hi;
    int          vals;
    int          mode;
    logic        exp_pin;
    logic [10:0] btn;

    repeat (3) @(negedge clk);
    reset = 1'b1;

    $display("[TB] test 1: 6-button pad, A and R");
    waitValid(3 * PERIOD, "t1_valid", waited);
    checkOutput("t1_vj", vj, 11'h041);
    checkOutput("t1_present", 11'(present), 11'd1);
    checkOutput("t1_six", 11'(six_button), 11'd1);
    checkOutput("t1_model_vj", m_vj, 11'h041);

    $display("[TB] test 2: 3-button pad, START U C");
    applyStimulus(1, 11'h0A8);
    waitValid(3 * PERIOD, "t2_valid", waited);
    checkOutput("t2_vj", vj, 11'h0A8);
    checkOutput("t2_present", 11'(present), 11'd1);
    checkOutput("t2_six", 11'(six_button), 11'd0);

    $display("[TB] test 3: no pad");
    applyStimulus(0, 11'h7FF);
    waitValid(3 * PERIOD, "t3_valid", waited);
    checkOutput("t3_vj", vj, 11'h000);
    checkOutput("t3_present", 11'(present), 11'd0);
    checkOutput("t3_six", 11'(six_button), 11'd0);
    waitValid(3 * PERIOD, "t3_valid2", waited);
    checkOutput("t3_valid_period", 11'(waited), 11'd96);

    $display("[TB] test 4: 6-button pad, X Y Z B and select waveform");
    applyStimulus(2, 11'h710);
    waitValid(3 * PERIOD, "t4_valid", waited);
    checkOutput("t4_vj", vj, 11'h710);
    checkOutput("t4_present", 11'(present), 11'd1);
    checkOutput("t4_six", 11'(six_button), 11'd1);
    wave_bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      exp_pin = (i < IDLE) ? 1'b1 : ((((i - IDLE) / PHASE) % 2) == 0);
      if (pin_7 !== exp_pin) wave_bad = wave_bad + 1;
    end
    checkOutput("t4_pin7_wave", 11'(wave_bad), 11'd0);

    $display("[TB] test 5: reset pulse during P3");
    applyStimulus(2, 11'h041);
    waitScanPos(2 * PHASE + PHASE / 2 + 3, 3 * PERIOD, "t5_reach_p3");
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_pin7_after_reset", 11'(pin_7), 11'd1);
    checkOutput("t5_vj_after_reset", vj, 11'h000);
    @(negedge clk);
    reset = 1'b1;
    hi   = 1;
    vals = 0;
    while (hi < 200) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) vals = vals + 1;
      if (pin_7 !== 1'b1) break;
      hi = hi + 1;
    end
    checkOutput("t5_high_cycles_before_p1", 11'(hi), 11'(IDLE + PHASE));
    checkOutput("t5_valids_before_p1", 11'(vals), 11'd0);

    $display("[TB] test 6: scan_en gating");
    scan_en = 1'b0;
    waitValid(3 * PERIOD, "t6_inflight_commit", waited);
    checkOutput("t6_inflight_vj", vj, 11'h041);
    holdQuiet(300, "t6_disabled");
    applyStimulus(1, 11'h0C0);
    scan_en = 1'b1;
    waitScanPos(2 * PHASE + 2, 3 * PERIOD, "t6_reach_p2");
    scan_en = 1'b0;
    waitValid(3 * PERIOD, "t6_valid", waited);
    checkOutput("t6_vj", vj, 11'h0C0);
    checkOutput("t6_six", 11'(six_button), 11'd0);
    holdQuiet(300, "t6_after_drop");

    $display("[TB] random scans");
    for (int n = 0; n < 12; n++) begin
      mode = int'($urandom_range(0, 2));
      btn  = 11'($urandom);
      if (btn[2] && btn[3]) btn[2] = 1'b0;
      applyStimulus(mode, btn);
      scan_en = 1'b1;
      waitValid(3 * PERIOD, "rand_valid", waited);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    errors = errors + 1;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md6_joystick_reader.md
MD6_JOYSTICK_READER -- requirements
Module: md6_joystick_reader

Interface
REQ-001 Parameter PHASE_CYCLES, default 280: clk cycles per select half-phase; minimum 4.
REQ-002 Parameter IDLE_CYCLES, default 56000: clk cycles with pin_7 high between scans; exceeds the pad's 1.5 ms counter-reset timeout at 28 MHz.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 scan_en  input  1  high permits a new scan to start.
REQ-006 data_bits  input  6  raw pad pins, active-low, asynchronous to clk.
REQ-007 pin_7  output  1  select line to the pad, registered.
REQ-008 vj  output  11  active-high buttons: [10]X [9]Z [8]Y [7]START [6]A [5]C [4]B [3]U [2]D [1]L [0]R.
REQ-009 present  output  1  a Mega Drive pad answered the last completed scan.
REQ-010 six_button  output  1  the last completed scan detected a 6-button pad.
REQ-011 valid  output  1  one-cycle strobe when vj, present and six_button update.

Function
REQ-012 data_bits SHALL pass through a 2-flop synchronizer; all decoding uses only the synchronized value.
REQ-013 States: WAIT, then P0..P7, then back to WAIT. Each Pn lasts exactly PHASE_CYCLES cycles. pin_7 is high in WAIT and in P0, P2, P4, P6, and low in P1, P3, P5, P7.
REQ-014 WAIT SHALL hold for IDLE_CYCLES cycles, then enter P0 only if scan_en=1; otherwise it remains in WAIT with pin_7 high.
REQ-015 Sampling happens only on the last cycle of each phase; scan_en is ignored once P0 has begun.
REQ-016 P0 sample, high select, bits [5:0] = C B R L D U, active-low.
REQ-017 P1 sample, low select, bits [5:4] = START A. Pad present iff bits [3:2]=00.
REQ-018 P2, P3 and P4 samples are discarded; these phases only advance the pad's internal counter.
REQ-019 P5 sample: six-button iff bits [3:0]=0000 and the pad is present.
REQ-020 P6 sample, high select, bits [2:0] = X Y Z, active-low; bit 3 (MODE) is ignored.
REQ-021 P7 is discarded; it returns the pad to its idle state.
REQ-022 All scan results SHALL be staged internally and committed atomically in the cycle after P7 ends, with valid=1 for that cycle.
REQ-023 Not present: vj=0, six_button=0, present=0.
REQ-024 Present but not six-button: vj[10:8]=000; vj[7:0] taken from the P0 and P1 samples.
REQ-025 Scan period is IDLE_CYCLES + 8*PHASE_CYCLES cycles. vj is stable between valid strobes.

Reset
REQ-026 While reset=0, at each clk edge:
- state=WAIT, counters=0, pin_7=1
- vj=0, present=0, six_button=0, valid=0
- synchronizer flops set to 6'b111111
REQ-027 Reset asserted mid-scan SHALL abandon the scan without committing. After release, WAIT runs a full IDLE_CYCLES before P0, so the pad's counter times out.

Structure
REQ-028 Package md6_pkg SHALL hold:
- the state enumeration
- vj bit-index constants
- pad pin-index constants for high and low select phases
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff, with a width parameter. All other logic lives in md6_joystick_reader.

Verification
REQ-030 Use a behavioural 6-button pad model, with PHASE_CYCLES=4 and IDLE_CYCLES=64.
REQ-031 Test 1: model pressing A and R, 6-button -> valid pulse; vj=11'h041, present=1, six_button=1.
REQ-032 Test 2: model in 3-button mode pressing START, U, C; P5 returns 11 in [3:0] -> vj=11'h0A8, six_button=0, present=1.
REQ-033 Test 3: data_bits tied to 6'b111111 -> vj=0, present=0, six_button=0, valid still pulses every 96 cycles.
REQ-034 Test 4: 6-button model pressing X, Y, Z, B -> vj=11'h710. Check the pin_7 waveform:
- high 64 cycles
- then 8 alternating phases of 4 cycles, starting high
REQ-035 Test 5: reset low for 1 cycle during P3 -> pin_7=1 the next cycle; no valid pulse; vj=0; the next P0 starts exactly 64 cycles after reset release.
REQ-036 Test 6: scan_en=0 -> pin_7 stays high indefinitely, no valid. Drop scan_en during P2 -> that scan completes and commits; no further scan starts.
